// File: rtl/loader_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
package loader_pkg;

    typedef enum logic [2:0] {IDLE, LEN0, LEN1, DATA, CHK, DONE, ERR} ldr_state_t;

    localparam logic [7:0] SYNC_DEFAULT = 8'hA5;

    function automatic logic [7:0] fold_chk(input logic [7:0] acc, input logic [7:0] b);
        return acc ^ b;
    endfunction

endpackage

// File: rtl/word_packer.sv
// Packs a byte stream into little-endian 32-bit words; word_valid pulses the
// cycle after the fourth byte of each word.
module word_packer (
    input  logic        clk,
    input  logic        rst,
    input  logic        byte_valid,
    input  logic [7:0]  byte_in,
    input  logic        clr,
    output logic        word_valid,
    output logic [31:0] word_out
);

    logic [1:0]  lane;
    logic [31:0] shreg;

    // Bytes enter at the top and shift down, so the first byte ends up in [7:0].
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lane       <= 2'd0;
            shreg      <= 32'd0;
            word_valid <= 1'b0;
        end else begin
            word_valid <= 1'b0;
            if (clr) begin
                lane <= 2'd0;
            end else if (byte_valid) begin
                shreg      <= {byte_in, shreg[31:8]};
                lane       <= lane + 2'd1;
                word_valid <= (lane == 2'd3);
            end
        end
    end

    assign word_out = shreg;

endmodule

// File: rtl/imem_loader.sv
// Boot-time loader: parses SYNC/LEN/payload/CHK frames, writes words into
// instruction memory and releases the CPU reset once a frame checks out.
module imem_loader
    import loader_pkg::*;
#(
    parameter int         DEPTH          = 256,
    parameter int         AW             = $clog2(DEPTH),
    parameter logic [7:0] SYNC_BYTE      = SYNC_DEFAULT,
    parameter logic       CPU_RST_ACTIVE = 1'b1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    input  logic [7:0]    in_data,
    output logic          in_ready,
    output logic          imem_we,
    output logic [AW-1:0] imem_addr,
    output logic [31:0]   imem_wdata,
    output logic          cpu_rst,
    output logic          busy,
    output logic          done,
    output logic          error
);

    localparam logic [16:0] DEPTH_W = 17'(DEPTH);

    ldr_state_t    state_q, state_d;
    logic [15:0]   len_q;
    logic [7:0]    chk_q;
    logic [AW-1:0] word_cnt_q;

    logic        xfer;
    logic        is_sync;
    logic        sync_start;
    logic        last_word;
    logic        final_write;
    logic        data_byte;
    logic [15:0] len_full;
    logic        word_valid;
    logic [31:0] word_out;

    assign xfer       = in_valid;
    assign is_sync    = (in_data == SYNC_BYTE);
    assign sync_start = xfer && is_sync &&
                        (state_q == IDLE || state_q == DONE || state_q == ERR);
    assign len_full   = {in_data, len_q[7:0]};
    assign last_word  = (16'(word_cnt_q) == len_q - 16'd1);
    // The final word's write cycle stays in DATA; a byte arriving then is the CHK byte.
    assign final_write = word_valid && last_word;
    assign data_byte   = xfer && (state_q == DATA) && !final_write;

    word_packer u_packer (
        .clk        (clk),
        .rst        (rst),
        .byte_valid (data_byte),
        .byte_in    (in_data),
        .clr        (sync_start),
        .word_valid (word_valid),
        .word_out   (word_out)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, DONE, ERR: begin
                if (xfer && is_sync) state_d = LEN0;
            end
            LEN0: begin
                if (xfer) state_d = LEN1;
            end
            LEN1: begin
                if (xfer) begin
                    if ({1'b0, len_full} > DEPTH_W) state_d = ERR;
                    else if (len_full == 16'd0)     state_d = CHK;
                    else                            state_d = DATA;
                end
            end
            DATA: begin
                if (final_write) begin
                    if (xfer) state_d = (in_data == chk_q) ? DONE : ERR;
                    else      state_d = CHK;
                end
            end
            CHK: begin
                if (xfer) state_d = (in_data == chk_q) ? DONE : ERR;
            end
            default: state_d = IDLE;
        endcase
    end

    // Frame bookkeeping: length, running checksum and the write address.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            len_q      <= 16'd0;
            chk_q      <= 8'd0;
            word_cnt_q <= '0;
        end else begin
            if (sync_start) begin
                len_q      <= 16'd0;
                chk_q      <= 8'd0;
                word_cnt_q <= '0;
            end else begin
                if (xfer && state_q == LEN0) begin
                    len_q[7:0] <= in_data;
                    chk_q      <= fold_chk(chk_q, in_data);
                end
                if (xfer && state_q == LEN1) begin
                    len_q[15:8] <= in_data;
                    chk_q       <= fold_chk(chk_q, in_data);
                end
                if (data_byte) begin
                    chk_q <= fold_chk(chk_q, in_data);
                end
                if (word_valid && !last_word) begin
                    word_cnt_q <= word_cnt_q + 1'b1;
                end
            end
        end
    end

    assign in_ready   = 1'b1;
    assign imem_we    = word_valid;
    assign imem_addr  = word_cnt_q;
    assign imem_wdata = word_out;
    assign done       = (state_q == DONE);
    assign error      = (state_q == ERR);
    assign busy       = (state_q == LEN0) || (state_q == LEN1) ||
                        (state_q == DATA) || (state_q == CHK);
    assign cpu_rst    = (state_q == DONE) ? ~CPU_RST_ACTIVE : CPU_RST_ACTIVE;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: frames are built from word arrays and the
// expected writes/status come from the frame contents and the checksum rule.
module tb_imem_loader;

    localparam int DEPTH = 256;
    localparam int AW    = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          in_valid = 1'b0;
    logic [7:0]    in_data = 8'd0;
    logic          in_ready;
    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_wdata;
    logic          cpu_rst;
    logic          busy;
    logic          done;
    logic          error;

    imem_loader #(.DEPTH(DEPTH), .AW(AW), .SYNC_BYTE(8'hA5), .CPU_RST_ACTIVE(1'b1)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .cpu_rst    (cpu_rst),
        .busy       (busy),
        .done       (done),
        .error      (error)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int last_xfer = 0;

    logic [31:0] words [DEPTH];
    int          fourth [DEPTH];

    int          wq_addr [$];
    logic [31:0] wq_data [$];
    int          wq_cyc  [$];

    // Reset value vector: in_ready, imem_we, addr, wdata, cpu_rst, busy, done, error
    localparam logic [45:0] RST_VEC = {1'b1, 1'b0, 8'd0, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0};

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst && imem_we) begin
            wq_addr.push_back(int'(imem_addr));
            wq_data.push_back(imem_wdata);
            wq_cyc.push_back(cyc);
        end
    end

    task automatic clear_q();
        wq_addr.delete();
        wq_data.delete();
        wq_cyc.delete();
    endtask

    // Entry/exit point is 1ns after a rising edge.
    task automatic send_byte(input logic [7:0] b, input int maxgap);
        int g;
        g = (maxgap > 0) ? int'($urandom_range(maxgap, 0)) : 0;
        repeat (g) begin
            @(posedge clk);
            #1;
        end
        in_valid = 1'b1;
        in_data  = b;
        @(posedge clk);
        #1;
        last_xfer = cyc;
        in_valid  = 1'b0;
        in_data   = 8'($urandom);
    endtask

    task automatic send_frame(input int len, input logic [7:0] chk_xor, input int maxgap, input int stop_at);
        logic [7:0] c;
        logic [7:0] b;
        logic [15:0] l16;
        int n;
        clear_q();
        l16 = 16'(len);
        c = l16[7:0] ^ l16[15:8];
        send_byte(8'hA5, maxgap);
        send_byte(l16[7:0], maxgap);
        send_byte(l16[15:8], maxgap);
        n = 0;
        for (int i = 0; i < len; i++) begin
            for (int j = 0; j < 4; j++) begin
                if (n >= stop_at) return;
                b = words[i][8*j +: 8];
                c = c ^ b;
                send_byte(b, maxgap);
                n++;
                if (j == 3) fourth[i] = last_xfer;
            end
        end
        send_byte(c ^ chk_xor, maxgap);
    endtask

    task automatic randomize_words(input int len);
        for (int i = 0; i < len; i++) words[i] = $urandom;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({in_ready, imem_we, imem_addr, imem_wdata, cpu_rst, busy, done, error} !== RST_VEC) begin
            failures++;
            $display("FAIL reset_values: got %h expected %h",
                     {in_ready, imem_we, imem_addr, imem_wdata, cpu_rst, busy, done, error}, RST_VEC);
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_single_word();
        words[0] = 32'h00100513;
        send_frame(1, 8'h00, 0, 4);
        checks++;
        if ({done, error, cpu_rst, busy} !== 4'b1000) begin
            failures++;
            $display("FAIL single_status: got done/err/cpurst/busy=%b expected 1000", {done, error, cpu_rst, busy});
        end
        checks++;
        if (wq_addr.size() !== 1) begin
            failures++;
            $display("FAIL single_count: got %0d writes expected 1", wq_addr.size());
        end else begin
            checks++;
            if (wq_addr[0] !== 0 || wq_data[0] !== 32'h00100513 || wq_cyc[0] !== fourth[0]) begin
                failures++;
                $display("FAIL single_write: got addr=%0d data=%h cyc=%0d expected addr=0 data=00100513 cyc=%0d",
                         wq_addr[0], wq_data[0], wq_cyc[0], fourth[0]);
            end
        end
    endtask

    task automatic test_bad_checksum();
        int len;
        words[0] = 32'h00100513;
        send_frame(1, 8'h0f, 0, 4);
        checks++;
        if ({done, error, cpu_rst, wq_addr.size() == 1} !== 4'b0111) begin
            failures++;
            $display("FAIL badchk_status: got done/err/cpurst/onewrite=%b expected 0111",
                     {done, error, cpu_rst, wq_addr.size() == 1});
        end
        len = $urandom_range(8, 1);
        randomize_words(len);
        send_frame(len, 8'h00, 0, len * 4);
        checks++;
        if ({done, error, cpu_rst} !== 3'b100) begin
            failures++;
            $display("FAIL badchk_recover: got done/err/cpurst=%b expected 100", {done, error, cpu_rst});
        end
        for (int i = 0; i < len; i++) begin
            checks++;
            if (i >= wq_addr.size() || wq_addr[i] !== i || wq_data[i] !== words[i]) begin
                failures++;
                $display("FAIL badchk_recover_write%0d: got %0d writes, expected addr=%0d data=%h", i, wq_addr.size(), i, words[i]);
            end
        end
    endtask

    task automatic test_len_limits();
        clear_q();
        send_byte(8'hA5, 0);
        send_byte(8'h01, 0);
        send_byte(8'h01, 0);
        checks++;
        if ({error, done, busy, cpu_rst} !== 4'b1001) begin
            failures++;
            $display("FAIL len_over: got err/done/busy/cpurst=%b expected 1001", {error, done, busy, cpu_rst});
        end
        repeat (4) send_byte(8'h3c, 0);
        checks++;
        if (wq_addr.size() !== 0 || error !== 1'b1) begin
            failures++;
            $display("FAIL len_over_quiet: got %0d writes error=%b expected 0 writes error=1", wq_addr.size(), error);
        end
        send_byte(8'hA5, 0);
        checks++;
        if ({error, done, busy, cpu_rst} !== 4'b0011) begin
            failures++;
            $display("FAIL err_resync: got err/done/busy/cpurst=%b expected 0011", {error, done, busy, cpu_rst});
        end
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        checks++;
        if ({done, error, cpu_rst, wq_addr.size() == 0} !== 4'b1001) begin
            failures++;
            $display("FAIL len_zero: got done/err/cpurst/nowrite=%b expected 1001",
                     {done, error, cpu_rst, wq_addr.size() == 0});
        end
        // A SYNC while DONE restarts the load and re-asserts cpu_rst.
        send_byte(8'hA5, 0);
        checks++;
        if ({done, busy, cpu_rst} !== 3'b011) begin
            failures++;
            $display("FAIL done_resync: got done/busy/cpurst=%b expected 011", {done, busy, cpu_rst});
        end
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
    endtask

    task automatic test_gaps_and_garbage();
        send_byte(8'h00, 0);
        send_byte(8'hFF, 0);
        send_byte(8'h12, 0);
        checks++;
        if ({done, busy, cpu_rst} !== 3'b100) begin
            failures++;
            $display("FAIL garbage_ignored: got done/busy/cpurst=%b expected 100", {done, busy, cpu_rst});
        end
        randomize_words(3);
        send_frame(3, 8'h00, 3, 12);
        checks++;
        if (wq_addr.size() !== 3 || done !== 1'b1) begin
            failures++;
            $display("FAIL gaps_count: got %0d writes done=%b expected 3 writes done=1", wq_addr.size(), done);
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (wq_addr[i] !== i || wq_data[i] !== words[i] || wq_cyc[i] !== fourth[i]) begin
                    failures++;
                    $display("FAIL gaps_write%0d: got addr=%0d data=%h cyc=%0d expected addr=%0d data=%h cyc=%0d",
                             i, wq_addr[i], wq_data[i], wq_cyc[i], i, words[i], fourth[i]);
                end
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        randomize_words(3);
        send_frame(3, 8'h00, 0, 10);
        @(posedge clk);
        #1;
        checks++;
        if (wq_addr.size() !== 2 || busy !== 1'b1 || imem_addr !== 8'd2) begin
            failures++;
            $display("FAIL mid_before_rst: got %0d writes busy=%b addr=%0d expected 2 writes busy=1 addr=2",
                     wq_addr.size(), busy, imem_addr);
        end
        #2 rst = 1'b0;
        #1;
        checks++;
        if ({in_ready, imem_we, imem_addr, imem_wdata, cpu_rst, busy, done, error} !== RST_VEC) begin
            failures++;
            $display("FAIL mid_reset_values: got %h expected %h",
                     {in_ready, imem_we, imem_addr, imem_wdata, cpu_rst, busy, done, error}, RST_VEC);
        end
        @(posedge clk);
        #1 rst = 1'b1;
        randomize_words(3);
        send_frame(3, 8'h00, 1, 12);
        checks++;
        if (done !== 1'b1 || wq_addr.size() !== 3) begin
            failures++;
            $display("FAIL mid_reload: got done=%b writes=%0d expected done=1 writes=3", done, wq_addr.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (wq_addr[i] !== i || wq_data[i] !== words[i]) begin
                    failures++;
                    $display("FAIL mid_reload_write%0d: got addr=%0d data=%h expected addr=%0d data=%h",
                             i, wq_addr[i], wq_data[i], i, words[i]);
                end
            end
        end
    endtask

    task automatic test_full_load();
        int bad;
        randomize_words(DEPTH);
        send_frame(DEPTH, 8'h00, 0, DEPTH * 4);
        repeat (5) begin
            @(posedge clk);
            #1;
        end
        checks++;
        if (wq_addr.size() !== DEPTH || done !== 1'b1 || cpu_rst !== 1'b0) begin
            failures++;
            $display("FAIL full_status: got writes=%0d done=%b cpurst=%b expected writes=%0d done=1 cpurst=0",
                     wq_addr.size(), done, cpu_rst, DEPTH);
        end else begin
            bad = 0;
            for (int i = 0; i < DEPTH; i++) begin
                if (wq_addr[i] !== i || wq_data[i] !== words[i] || wq_cyc[i] !== fourth[i]) bad++;
            end
            checks++;
            if (bad !== 0) begin
                failures++;
                $display("FAIL full_writes: got %0d wrong writes expected 0", bad);
            end
            checks++;
            if (wq_addr[DEPTH-1] !== DEPTH - 1) begin
                failures++;
                $display("FAIL full_last_addr: got %0d expected %0d", wq_addr[DEPTH-1], DEPTH - 1);
            end
        end
    endtask

    task automatic test_back_to_back();
        int len;
        logic [7:0] cx;
        logic ok;
        for (int it = 0; it < 6; it++) begin
            len = $urandom_range(6, 1);
            randomize_words(len);
            ok = ($urandom_range(2, 0) != 0);
            cx = ok ? 8'h00 : 8'($urandom_range(255, 1));
            send_frame(len, cx, $urandom_range(2, 0), len * 4);
            checks++;
            if ({done, error, cpu_rst, busy} !== {ok, !ok, !ok, 1'b0}) begin
                failures++;
                $display("FAIL b2b%0d_status: got done/err/cpurst/busy=%b expected %b",
                         it, {done, error, cpu_rst, busy}, {ok, !ok, !ok, 1'b0});
            end
            checks++;
            if (wq_addr.size() !== len) begin
                failures++;
                $display("FAIL b2b%0d_count: got %0d writes expected %0d", it, wq_addr.size(), len);
            end else begin
                for (int i = 0; i < len; i++) begin
                    checks++;
                    if (wq_addr[i] !== i || wq_data[i] !== words[i] || wq_cyc[i] !== fourth[i]) begin
                        failures++;
                        $display("FAIL b2b%0d_write%0d: got addr=%0d data=%h cyc=%0d expected addr=%0d data=%h cyc=%0d",
                                 it, i, wq_addr[i], wq_data[i], wq_cyc[i], i, words[i], fourth[i]);
                    end
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_bad_checksum();
        test_len_limits();
        test_gaps_and_garbage();
        test_reset_mid_frame();
        test_full_load();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
